i_serdes_word_aligner: RTL and testbench

I_SERDES_WORD_ALIGNER -- requirements
Module: i_serdes_word_aligner

---
 rtl/i_serdes_align_pkg.sv | 21 ++
 rtl/i_serdes_word_aligner.sv | 165 ++++++++++++++++
 tb/tb_i_serdes_word_aligner.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/i_serdes_align_pkg.sv
// Shared definitions for the I_SERDES word aligner.
//   state_e           : aligner FSM state encoding
//   TRAIN_PATTERN_DEF : default training word (every rotation of it is distinct)
//   MATCH_COUNT_DEF   : default number of consecutive matching words needed to lock
//   SLIP_WAIT_DEF     : default settle time, in cycles, after each bitslip pulse
package i_serdes_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

    localparam logic [3:0] TRAIN_PATTERN_DEF = 4'b0011;
    localparam int         MATCH_COUNT_DEF   = 4;
    localparam int         SLIP_WAIT_DEF     = 8;

endpackage

// File: rtl/i_serdes_word_aligner.sv
// Word aligner for an I_SERDES deserializer. It searches the incoming words
// for the training pattern and issues single-cycle bitslip requests until
// MATCH_COUNT consecutive valid words match. Once locked, data is passed
// through with one cycle of latency.
// Ports:
//   CLK_IN      in   sole clock, rising edge
//   reset       in   synchronous, active-high reset
//   ALIGN_EN    in   enables alignment; low returns the FSM to IDLE
//   Q_IN        in   deserialized word from I_SERDES Q
//   DATA_VALID  in   Q_IN qualifier
//   DPA_LOCK    in   DPA lock status
//   DPA_ERROR   in   DPA error status
//   BITSLIP_ADJ out  one-cycle slip request to I_SERDES
//   WORD_OUT    out  aligned data word
//   WORD_VALID  out  WORD_OUT qualifier
//   ALIGNED     out  high while locked
//   ALIGN_FAIL  out  high after all rotations were tried without a lock
//   SLIP_CNT    out  slips issued in the current attempt
module i_serdes_word_aligner
    import i_serdes_align_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(TRAIN_PATTERN_DEF),
    parameter int               MATCH_COUNT   = MATCH_COUNT_DEF,
    parameter int               SLIP_WAIT     = SLIP_WAIT_DEF
) (
    input  logic                         CLK_IN,
    input  logic                         reset,
    input  logic                         ALIGN_EN,
    input  logic [WIDTH-1:0]             Q_IN,
    input  logic                         DATA_VALID,
    input  logic                         DPA_LOCK,
    input  logic                         DPA_ERROR,
    output logic                         BITSLIP_ADJ,
    output logic [WIDTH-1:0]             WORD_OUT,
    output logic                         WORD_VALID,
    output logic                         ALIGNED,
    output logic                         ALIGN_FAIL,
    output logic [$clog2(WIDTH+1)-1:0]   SLIP_CNT
);

    localparam int SC_W = $clog2(WIDTH + 1);
    localparam int MC_W = $clog2(MATCH_COUNT + 1);
    localparam int WC_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    state_e            state_q, state_d;
    logic [MC_W-1:0]   match_q, match_d;
    logic [SC_W-1:0]   slip_q, slip_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [WIDTH-1:0]  word_out_q, word_out_d;
    logic              word_valid_q, word_valid_d;
    logic              bitslip_q, bitslip_d;
    logic              aligned_q, aligned_d;
    logic              fail_q, fail_d;
    logic              abort;
    logic              stay_locked;

    // Match counter stops at MATCH_COUNT rather than wrapping.
    function automatic logic [MC_W-1:0] match_sat_inc(input logic [MC_W-1:0] v);
        if (v == MC_W'(MATCH_COUNT))
            return v;
        return v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        slip_d     = slip_q;
        wait_d     = wait_q;
        abort      = !ALIGN_EN || !DPA_LOCK || DPA_ERROR;

        case (state_q)
            ST_IDLE: begin
                match_d = '0;
                slip_d  = '0;
                wait_d  = '0;
                if (!abort)
                    state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (DATA_VALID) begin
                    if (Q_IN == TRAIN_PATTERN) begin
                        match_d = match_sat_inc(match_q);
                        if (match_d == MC_W'(MATCH_COUNT))
                            state_d = ST_LOCKED;
                    end else begin
                        match_d = '0;
                        // SLIP_CNT advances together with the pulse it counts.
                        if (slip_q < SC_W'(WIDTH - 1)) begin
                            state_d = ST_SLIP;
                            slip_d  = slip_q + 1'b1;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end
                end
            end
            ST_SLIP: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WC_W'(SLIP_WAIT - 1)) begin
                    wait_d  = '0;
                    match_d = '0;
                    state_d = ST_SEARCH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_LOCKED: ;
            ST_FAIL:   ;
            default:   state_d = ST_IDLE;
        endcase

        // Loss of enable or DPA health wins over any same-cycle lock or slip.
        if (state_q != ST_IDLE && abort) begin
            state_d = ST_IDLE;
            match_d = '0;
            slip_d  = '0;
            wait_d  = '0;
        end

        // Data passes only while the FSM stays locked, so an abort drops
        // WORD_VALID on the same edge that clears ALIGNED.
        stay_locked  = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
        word_out_d   = stay_locked ? Q_IN : word_out_q;
        word_valid_d = stay_locked && DATA_VALID;
        bitslip_d    = (state_d == ST_SLIP);
        aligned_d    = (state_d == ST_LOCKED);
        fail_d       = (state_d == ST_FAIL);
    end

    always_ff @(posedge CLK_IN) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            match_q      <= '0;
            slip_q       <= '0;
            wait_q       <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            slip_q       <= slip_d;
            wait_q       <= wait_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            bitslip_q    <= bitslip_d;
            aligned_q    <= aligned_d;
            fail_q       <= fail_d;
        end
    end

    assign BITSLIP_ADJ = bitslip_q;
    assign WORD_OUT    = word_out_q;
    assign WORD_VALID  = word_valid_q;
    assign ALIGNED     = aligned_q;
    assign ALIGN_FAIL  = fail_q;
    assign SLIP_CNT    = slip_q;

endmodule

// File: tb/tb_i_serdes_word_aligner.sv
// Directed testbench for i_serdes_word_aligner (default parameters:
// WIDTH=4, TRAIN_PATTERN=0011, MATCH_COUNT=4, SLIP_WAIT=8).
module tb_i_serdes_word_aligner;

    logic       CLK_IN = 1'b0;
    logic       reset;
    logic       ALIGN_EN;
    logic [3:0] Q_IN;
    logic       DATA_VALID;
    logic       DPA_LOCK;
    logic       DPA_ERROR;
    logic       BITSLIP_ADJ;
    logic [3:0] WORD_OUT;
    logic       WORD_VALID;
    logic       ALIGNED;
    logic       ALIGN_FAIL;
    logic [2:0] SLIP_CNT;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_total = 0;
    int dbl_high    = 0;
    logic prev_bs   = 1'b0;
    int p0;
    logic [3:0] rq;
    logic       rv;

    i_serdes_word_aligner dut (
        .CLK_IN     (CLK_IN),
        .reset      (reset),
        .ALIGN_EN   (ALIGN_EN),
        .Q_IN       (Q_IN),
        .DATA_VALID (DATA_VALID),
        .DPA_LOCK   (DPA_LOCK),
        .DPA_ERROR  (DPA_ERROR),
        .BITSLIP_ADJ(BITSLIP_ADJ),
        .WORD_OUT   (WORD_OUT),
        .WORD_VALID (WORD_VALID),
        .ALIGNED    (ALIGNED),
        .ALIGN_FAIL (ALIGN_FAIL),
        .SLIP_CNT   (SLIP_CNT)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Bitslip pulse bookkeeping, sampled on the inactive edge.
    always @(negedge CLK_IN) begin
        if (BITSLIP_ADJ) pulse_total <= pulse_total + 1;
        if (BITSLIP_ADJ && prev_bs) dbl_high <= dbl_high + 1;
        prev_bs <= BITSLIP_ADJ;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK_IN);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_slip_cnt"}, 32'(SLIP_CNT),    32'd0);
        check({tag, "_bitslip"},  32'(BITSLIP_ADJ), 32'd0);
        check({tag, "_aligned"},  32'(ALIGNED),     32'd0);
        check({tag, "_fail"},     32'(ALIGN_FAIL),  32'd0);
        check({tag, "_wvalid"},   32'(WORD_VALID),  32'd0);
        check({tag, "_word"},     32'(WORD_OUT),    32'd0);
    endtask

    initial begin
        reset = 1'b1; ALIGN_EN = 1'b0; Q_IN = 4'h0; DATA_VALID = 1'b0;
        DPA_LOCK = 1'b0; DPA_ERROR = 1'b0;
        step(2);
        check_all_zero("reset");
        reset = 1'b0;

        // Clean lock: 1 edge to SEARCH, 4 matching words, lock on edge 5.
        ALIGN_EN = 1'b1; DPA_LOCK = 1'b1; Q_IN = 4'b0011; DATA_VALID = 1'b1;
        p0 = pulse_total;
        step(4);
        check("t1_not_yet_aligned", 32'(ALIGNED), 32'd0);
        step(1);
        check("t1_aligned", 32'(ALIGNED), 32'd1);
        check("t1_slip_cnt", 32'(SLIP_CNT), 32'd0);
        step(1);
        check("t1_wvalid", 32'(WORD_VALID), 32'd1);
        check("t1_word", 32'(WORD_OUT), 32'h3);
        check("t1_no_pulses", 32'(pulse_total - p0), 32'd0);

        // One slip: mismatch on edge 2, 8 wait cycles (edges 3..10), lock on edge 15.
        do_reset();
        Q_IN = 4'b0110;
        p0 = pulse_total;
        step(2);
        check("t2_bitslip_hi", 32'(BITSLIP_ADJ), 32'd1);
        check("t2_slip_cnt1", 32'(SLIP_CNT), 32'd1);
        Q_IN = 4'b0011;
        step(1);
        check("t2_bitslip_lo", 32'(BITSLIP_ADJ), 32'd0);
        step(7);
        check("t2_wait_end", 32'(ALIGNED), 32'd0);
        step(4);
        check("t2_before_lock", 32'(ALIGNED), 32'd0);
        step(1);
        check("t2_aligned", 32'(ALIGNED), 32'd1);
        check("t2_slip_cnt", 32'(SLIP_CNT), 32'd1);
        check("t2_one_pulse", 32'(pulse_total - p0), 32'd1);

        // Never matching: slips on edges 2, 12, 22, fail on edge 32.
        do_reset();
        Q_IN = 4'b1111;
        p0 = pulse_total;
        step(31);
        check("t3_not_failed", 32'(ALIGN_FAIL), 32'd0);
        step(1);
        check("t3_fail", 32'(ALIGN_FAIL), 32'd1);
        check("t3_slip_cnt", 32'(SLIP_CNT), 32'd3);
        check("t3_pulses", 32'(pulse_total - p0), 32'd3);
        step(5);
        check("t3_fail_hold", 32'(ALIGN_FAIL), 32'd1);
        check("t3_pulses_hold", 32'(pulse_total - p0), 32'd3);
        ALIGN_EN = 1'b0;
        step(1);
        check("t3_fail_clear", 32'(ALIGN_FAIL), 32'd0);
        check("t3_slip_clear", 32'(SLIP_CNT), 32'd0);

        // Lock, then a one-cycle DPA error drops lock, then re-lock.
        ALIGN_EN = 1'b1; Q_IN = 4'b0011;
        step(5);
        check("t4_aligned", 32'(ALIGNED), 32'd1);
        step(1);
        check("t4_wvalid", 32'(WORD_VALID), 32'd1);
        DPA_ERROR = 1'b1;
        step(1);
        check("t4_err_aligned", 32'(ALIGNED), 32'd0);
        check("t4_err_wvalid", 32'(WORD_VALID), 32'd0);
        DPA_ERROR = 1'b0;
        step(4);
        check("t4_relock_pending", 32'(ALIGNED), 32'd0);
        step(1);
        check("t4_relock", 32'(ALIGNED), 32'd1);

        // Enable drop on the final matching word must win over the lock.
        DPA_LOCK = 1'b0;
        step(1);
        check("t5_idle_aligned", 32'(ALIGNED), 32'd0);
        check("t5_word_held", 32'(WORD_OUT), 32'h3);
        DPA_LOCK = 1'b1;
        step(4);
        ALIGN_EN = 1'b0;
        step(1);
        check("t5_override", 32'(ALIGNED), 32'd0);
        ALIGN_EN = 1'b1;
        step(5);
        check("t5_aligned_again", 32'(ALIGNED), 32'd1);

        // Reset while waiting after the second slip.
        DPA_LOCK = 1'b0;
        step(1);
        DPA_LOCK = 1'b1; Q_IN = 4'b1111;
        step(14);
        check("t6_slip_cnt2", 32'(SLIP_CNT), 32'd2);
        check("t6_word_held", 32'(WORD_OUT), 32'h3);
        do_reset();
        check_all_zero("t6_reset");

        // Reset during the bitslip pulse truncates it.
        step(2);
        check("t7_bitslip_hi", 32'(BITSLIP_ADJ), 32'd1);
        do_reset();
        check("t7_bitslip_cut", 32'(BITSLIP_ADJ), 32'd0);
        check("t7_slip_cnt", 32'(SLIP_CNT), 32'd0);

        // Locked pass-through with random words and qualifiers.
        Q_IN = 4'b0011;
        step(5);
        check("t8_aligned", 32'(ALIGNED), 32'd1);
        for (int i = 0; i < 1000; i++) begin
            rq = 4'($urandom);
            rv = 1'($urandom);
            Q_IN = rq; DATA_VALID = rv;
            step(1);
            check("t8_word", 32'(WORD_OUT), 32'(rq));
            check("t8_wvalid", 32'(WORD_VALID), 32'(rv));
        end

        check("no_back_to_back_slip", 32'(dbl_high), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
